// File: rtl/prosparsity_pkg.sv
// Shared definitions for the ProSparsity dispatcher slice.
// Contents: tile geometry (rows, pattern width), FIFO sizing, the "no prefix"
// row id, PE micro-op encodings, dispatcher FSM states and the task record
// carried through the task FIFO.
package prosparsity_pkg;

    localparam int N          = 256;
    localparam int M          = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int IW         = $clog2(N);
    localparam int CW         = $clog2(M);
    localparam int FW         = $clog2(FIFO_DEPTH) + 1;
    localparam int CNTW       = 16;

    localparam logic [IW-1:0] NULL_ID = IW'(255);

    typedef enum logic [1:0] {
        OP_INIT_ZERO = 2'd0,
        OP_INIT_COPY = 2'd1,
        OP_ACCUM     = 2'd2,
        OP_FINISH    = 2'd3
    } pe_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_ACC  = 2'd2,
        S_FIN  = 2'd3
    } state_e;

    typedef struct packed {
        logic [IW-1:0] row_id;
        logic [IW-1:0] prefix_id;
        logic [M-1:0]  pattern;
        logic          is_root;
    } task_t;

endpackage

// File: rtl/task_fifo.sv
// Synchronous task FIFO holding pruned tasks awaiting dispatch.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   push, wdata : write strobe and task record (ignored when full)
//   pop         : advance head (ignored when empty)
//   head        : task at the head (valid while count != 0)
//   count       : current occupancy, 0..DEPTH
module task_fifo
    import prosparsity_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  task_t                      wdata,
    input  logic                       pop,
    output task_t                      head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

    task_t         mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != FULL_LVL);
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/prosparsity_dispatcher.sv
// Dispatcher: buffers pruned tasks, holds each row until its prefix row has
// completed, then serializes it into PE micro-ops INIT, ACCUM per set bit
// (lowest column first), FINISH.
// Ports:
//   clk, rst_n                        : clock, synchronous active-low reset
//   prefix_id, row_id_in, pattern     : incoming task fields
//   prune_valid, prune_done           : task strobe, end-of-tile pulse
//   dispatch_ready                    : FIFO has room incl. one skid slot
//   pe_valid/pe_ready/pe_op/pe_row_id/pe_prefix_id/pe_col_idx : micro-op stream
//   pe_done_valid, pe_done_row        : row completion from the PE
//   tile_start                        : clear tile bookkeeping (idle+empty only)
//   all_done                          : tile fully processed (level)
//   err                               : sticky overflow / illegal tile_start
//
// state  | meaning
// S_IDLE | waiting for an eligible head task; pops it into working regs
// S_INIT | presenting INIT_ZERO (root) or INIT_COPY (with prefix)
// S_ACC  | presenting ACCUM for lowest remaining pattern bit
// S_FIN  | presenting FINISH for the working row
module prosparsity_dispatcher
    import prosparsity_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] prefix_id,
    input  logic [IW-1:0] row_id_in,
    input  logic [M-1:0]  pattern,
    input  logic          prune_valid,
    input  logic          prune_done,
    output logic          dispatch_ready,
    output logic          pe_valid,
    input  logic          pe_ready,
    output logic [1:0]    pe_op,
    output logic [IW-1:0] pe_row_id,
    output logic [IW-1:0] pe_prefix_id,
    output logic [CW-1:0] pe_col_idx,
    input  logic          pe_done_valid,
    input  logic [IW-1:0] pe_done_row,
    input  logic          tile_start,
    output logic          all_done,
    output logic          err
);

    localparam logic [FW-1:0] DEPTH_LVL = FW'(FIFO_DEPTH);
    localparam logic [FW-1:0] READY_LVL = FW'(FIFO_DEPTH - 2);

    state_e          state, state_nxt;
    task_t           head, work, wdata;
    logic [FW-1:0]   fifo_count;
    logic            fifo_empty, fifo_full;
    logic            push, pop, head_eligible, tile_ok;
    logic [N-1:0]    done_bitmap;
    logic [CNTW-1:0] accepted_cnt, done_cnt;
    logic            done_latch;
    logic [CW-1:0]   low_idx;
    logic [M-1:0]    pattern_cleared;

    assign fifo_empty     = (fifo_count == '0);
    assign fifo_full      = (fifo_count == DEPTH_LVL);
    assign dispatch_ready = (fifo_count <= READY_LVL);
    assign push           = prune_valid && !fifo_full;

    assign wdata.row_id    = row_id_in;
    assign wdata.prefix_id = prefix_id;
    assign wdata.pattern   = pattern;
    assign wdata.is_root   = (prefix_id == NULL_ID) || (prefix_id == row_id_in);

    task_fifo #(.DEPTH(FIFO_DEPTH)) u_task_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .head  (head),
        .count (fifo_count)
    );

    assign head_eligible = !fifo_empty && (head.is_root || done_bitmap[head.prefix_id]);
    assign tile_ok       = tile_start && (state == S_IDLE) && fifo_empty;

    // Lowest set bit wins: scan from the top so the last hit is the lowest.
    always_comb begin
        low_idx = '0;
        for (int i = M - 1; i >= 0; i--) begin
            if (work.pattern[i]) low_idx = CW'(i);
        end
    end

    assign pattern_cleared = work.pattern & (work.pattern - 1'b1);

    always_comb begin
        state_nxt    = state;
        pop          = 1'b0;
        pe_valid     = 1'b0;
        pe_op        = OP_INIT_ZERO;
        pe_row_id    = '0;
        pe_prefix_id = '0;
        pe_col_idx   = '0;
        case (state)
            S_IDLE: begin
                if (head_eligible) begin
                    pop       = 1'b1;
                    state_nxt = S_INIT;
                end
            end
            S_INIT: begin
                pe_valid  = 1'b1;
                pe_row_id = work.row_id;
                if (!work.is_root) begin
                    pe_op        = OP_INIT_COPY;
                    pe_prefix_id = work.prefix_id;
                end
                if (pe_ready) state_nxt = (work.pattern != '0) ? S_ACC : S_FIN;
            end
            S_ACC: begin
                pe_valid   = 1'b1;
                pe_op      = OP_ACCUM;
                pe_row_id  = work.row_id;
                pe_col_idx = low_idx;
                if (pe_ready && (pattern_cleared == '0)) state_nxt = S_FIN;
            end
            S_FIN: begin
                pe_valid  = 1'b1;
                pe_op     = OP_FINISH;
                pe_row_id = work.row_id;
                if (pe_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            work  <= '0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                work <= head;
            end else if ((state == S_ACC) && pe_ready) begin
                work.pattern <= pattern_cleared;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_bitmap  <= '0;
            accepted_cnt <= '0;
            done_cnt     <= '0;
            done_latch   <= 1'b0;
            err          <= 1'b0;
        end else begin
            if ((tile_start && !tile_ok) || (prune_valid && fifo_full)) err <= 1'b1;
            if (tile_ok) begin
                done_bitmap  <= '0;
                accepted_cnt <= {{(CNTW-1){1'b0}}, push};
                done_cnt     <= '0;
                done_latch   <= 1'b0;
            end else begin
                if (push) accepted_cnt <= accepted_cnt + 1'b1;
                if (pe_done_valid) begin
                    done_bitmap[pe_done_row] <= 1'b1;
                    done_cnt                 <= done_cnt + 1'b1;
                end
                if (prune_done) done_latch <= 1'b1;
            end
        end
    end

    assign all_done = done_latch && fifo_empty && (state == S_IDLE) && (done_cnt == accepted_cnt);

endmodule

// File: tb/tb_prosparsity_dispatcher.sv
module tb_prosparsity_dispatcher;
    import prosparsity_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  prefix_id = '0, row_id_in = '0, pe_done_row = '0;
    logic [15:0] pattern = '0;
    logic        prune_valid = 1'b0, prune_done = 1'b0, pe_ready = 1'b0;
    logic        pe_done_valid = 1'b0, tile_start = 1'b0;
    logic        dispatch_ready, pe_valid, all_done, err;
    logic [1:0]  pe_op;
    logic [7:0]  pe_row_id, pe_prefix_id;
    logic [3:0]  pe_col_idx;

    prosparsity_dispatcher dut (
        .clk(clk), .rst_n(rst_n), .prefix_id(prefix_id), .row_id_in(row_id_in),
        .pattern(pattern), .prune_valid(prune_valid), .prune_done(prune_done),
        .dispatch_ready(dispatch_ready), .pe_valid(pe_valid), .pe_ready(pe_ready),
        .pe_op(pe_op), .pe_row_id(pe_row_id), .pe_prefix_id(pe_prefix_id),
        .pe_col_idx(pe_col_idx), .pe_done_valid(pe_done_valid), .pe_done_row(pe_done_row),
        .tile_start(tile_start), .all_done(all_done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] row;
        logic [7:0] pre;
        logic [3:0] col;
    } uop_t;

    int   n_run = 0, n_fail = 0;
    int   cyc = 0;
    int   last_push_edge = 0;
    bit   rand_ready = 0;
    uop_t obs[$], exp_q[$];
    int   obs_edge[$];
    int   stall_viol = 0;
    bit   prev_stall = 0;
    uop_t prev_u, mon_u;

    always @(posedge clk) cyc <= cyc + 1;

    // Transfer monitor: records every accepted micro-op with the edge it transfers on,
    // and flags any payload change or withdrawal while stalled.
    always @(negedge clk) begin
        mon_u = {pe_op, pe_row_id, pe_prefix_id, pe_col_idx};
        if (rst_n) begin
            if (prev_stall && (!pe_valid || mon_u !== prev_u)) stall_viol++;
            if (pe_valid && pe_ready) begin
                obs.push_back(mon_u);
                obs_edge.push_back(cyc + 1);
            end
            prev_stall = pe_valid && !pe_ready;
            prev_u     = mon_u;
        end else begin
            prev_stall = 0;
        end
    end

    // Reference: one INIT, one ACCUM per set column ascending, one FINISH.
    function automatic void add_exp(input logic [7:0] row, input logic [7:0] pre,
                                    input logic [15:0] pat);
        bit root;
        root = (pre == 8'd255) || (pre == row);
        exp_q.push_back({root ? 2'd0 : 2'd1, row, root ? 8'd0 : pre, 4'd0});
        for (int c = 0; c < 16; c++)
            if (pat[c]) exp_q.push_back({2'd2, row, 8'd0, 4'(c)});
        exp_q.push_back({2'd3, row, 8'd0, 4'd0});
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
        if (rand_ready) pe_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_task(input logic [7:0] row, input logic [7:0] pre, input logic [15:0] pat);
        row_id_in = row; prefix_id = pre; pattern = pat; prune_valid = 1'b1;
        cycle();
        prune_valid = 1'b0;
        last_push_edge = cyc;
    endtask

    task automatic complete(input logic [7:0] row);
        pe_done_row = row; pe_done_valid = 1'b1;
        cycle();
        pe_done_valid = 1'b0;
    endtask

    task automatic wait_ops(input int n, input int budget);
        int k = 0;
        while (obs.size() < n && k < budget) begin cycle(); k++; end
        repeat (4) cycle();
    endtask

    task automatic wait_finish(input logic [7:0] row, output bit ok);
        ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            foreach (obs[i]) if (obs[i].op == 2'd3 && obs[i].row == row) ok = 1;
            if (!ok) cycle();
        end
    endtask

    task automatic clear_q();
        obs.delete(); obs_edge.delete(); exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        do_reset();
        n_run++; if (dispatch_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", dispatch_ready); end
        n_run++; if (pe_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", pe_valid); end
        n_run++; if (pe_op !== 2'd0) begin n_fail++; $display("FAIL reset_op: got %0d expected 0", pe_op); end
        n_run++; if (pe_row_id !== 8'd0) begin n_fail++; $display("FAIL reset_row: got %0d expected 0", pe_row_id); end
        n_run++; if (all_done !== 1'b0) begin n_fail++; $display("FAIL reset_all_done: got %b expected 0", all_done); end
        n_run++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    endtask

    task automatic test_root_latency();
        int t;
        clear_q();
        pe_ready = 1'b1;
        push_task(8'd3, 8'd255, 16'h0005);
        t = last_push_edge;
        add_exp(8'd3, 8'd255, 16'h0005);
        wait_ops(exp_q.size(), 40);
        n_run++; if (obs.size() != exp_q.size()) begin n_fail++; $display("FAIL root_count: got %0d expected %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_run++; if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL root_op[%0d]: got %h expected %h", i, obs[i], exp_q[i]); end
        end
        if (obs.size() == 4) begin
            n_run++; if (obs_edge[0] != t + 2) begin n_fail++; $display("FAIL root_init_edge: got %0d expected %0d", obs_edge[0], t + 2); end
            n_run++; if (obs_edge[3] != t + 3 + $countones(16'h0005)) begin n_fail++; $display("FAIL root_finish_edge: got %0d expected %0d", obs_edge[3], t + 5); end
        end
    endtask

    task automatic test_dependency();
        int e;
        clear_q();
        pe_ready = 1'b1;
        push_task(8'd7, 8'd3, 16'h8000);
        repeat (10) cycle();
        n_run++; if (obs.size() != 0) begin n_fail++; $display("FAIL dep_wait_ops: got %0d expected 0", obs.size()); end
        n_run++; if (pe_valid !== 1'b0) begin n_fail++; $display("FAIL dep_wait_valid: got %b expected 0", pe_valid); end
        complete(8'd3);
        e = cyc;
        add_exp(8'd7, 8'd3, 16'h8000);
        wait_ops(exp_q.size(), 40);
        n_run++; if (obs.size() != exp_q.size()) begin n_fail++; $display("FAIL dep_count: got %0d expected %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_run++; if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL dep_op[%0d]: got %h expected %h", i, obs[i], exp_q[i]); end
        end
        if (obs.size() > 0) begin
            n_run++; if (obs_edge[0] != e + 2) begin n_fail++; $display("FAIL dep_init_edge: got %0d expected %0d", obs_edge[0], e + 2); end
        end
        complete(8'd7);
    endtask

    task automatic test_random_stall();
        logic [7:0]  row, pre;
        logic [15:0] pat;
        int k;
        clear_q();
        stall_viol = 0;
        rand_ready = 1;
        for (int i = 0; i < 12; i++) begin
            row = 8'(40 + i);
            case ($urandom_range(0, 3))
                0: pre = 8'd255;
                1: pre = row;
                2: pre = 8'd3;
                default: pre = 8'd7;
            endcase
            pat = 16'($urandom);
            if ($urandom_range(0, 4) == 0) pat = 16'h0000;
            k = 0;
            while (!dispatch_ready && k < 300) begin cycle(); k++; end
            push_task(row, pre, pat);
            add_exp(row, pre, pat);
        end
        wait_ops(exp_q.size(), 3000);
        rand_ready = 0;
        pe_ready = 1'b1;
        repeat (4) cycle();
        n_run++; if (obs.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_count: got %0d expected %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_run++; if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_op[%0d]: got %h expected %h", i, obs[i], exp_q[i]); end
        end
        n_run++; if (stall_viol != 0) begin n_fail++; $display("FAIL rnd_stall_stable: got %0d violations expected 0", stall_viol); end
        for (int i = 0; i < 12; i++) complete(8'(40 + i));
    endtask

    task automatic test_illegal_tile_start();
        bit seen = 0;
        do_reset();
        clear_q();
        n_run++; if (err !== 1'b0) begin n_fail++; $display("FAIL ill_err_before: got %b expected 0", err); end
        pe_ready = 1'b1;
        push_task(8'd30, 8'd255, 16'hFFFF);
        add_exp(8'd30, 8'd255, 16'hFFFF);
        for (int k = 0; k < 20 && !seen; k++) begin
            if (pe_valid && pe_op == 2'd2) seen = 1; else cycle();
        end
        n_run++; if (!seen) begin n_fail++; $display("FAIL ill_reach_acc: got no ACCUM expected ACCUM"); end
        tile_start = 1'b1;
        cycle();
        tile_start = 1'b0;
        n_run++; if (err !== 1'b1) begin n_fail++; $display("FAIL ill_err_set: got %b expected 1", err); end
        wait_ops(exp_q.size(), 60);
        n_run++; if (obs.size() != exp_q.size()) begin n_fail++; $display("FAIL ill_count: got %0d expected %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_run++; if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL ill_op[%0d]: got %h expected %h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_fifo_full();
        int  model_cnt = 0;
        bit  model_err = 0;
        logic [15:0] pat;
        do_reset();
        clear_q();
        pe_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            pat = 16'($urandom);
            if (model_cnt < FIFO_DEPTH) begin
                model_cnt++;
                add_exp(8'(101 + i), 8'd100, pat);
            end else begin
                model_err = 1;
            end
            push_task(8'(101 + i), 8'd100, pat);
            n_run++; if (dispatch_ready !== (model_cnt <= FIFO_DEPTH - 2)) begin n_fail++; $display("FAIL full_ready[%0d]: got %b expected %b", i, dispatch_ready, model_cnt <= FIFO_DEPTH - 2); end
            n_run++; if (err !== model_err) begin n_fail++; $display("FAIL full_err[%0d]: got %b expected %b", i, err, model_err); end
        end
        n_run++; if (obs.size() != 0) begin n_fail++; $display("FAIL full_no_issue: got %0d ops expected 0", obs.size()); end
        complete(8'd100);
        wait_ops(exp_q.size(), 400);
        n_run++; if (obs.size() != exp_q.size()) begin n_fail++; $display("FAIL full_count: got %0d expected %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_run++; if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_op[%0d]: got %h expected %h", i, obs[i], exp_q[i]); end
        end
        for (int i = 0; i < 8; i++) complete(8'(101 + i));
    endtask

    task automatic test_all_done();
        logic [7:0]  rows[4] = '{8'd20, 8'd21, 8'd22, 8'd23};
        logic [7:0]  pres[4] = '{8'd255, 8'd20, 8'd21, 8'd255};
        logic [15:0] pat;
        bit ok;
        clear_q();
        pe_ready = 1'b1;
        tile_start = 1'b1;
        cycle();
        tile_start = 1'b0;
        n_run++; if (err !== 1'b1) begin n_fail++; $display("FAIL ad_err_sticky: got %b expected 1", err); end
        for (int i = 0; i < 4; i++) begin
            pat = 16'($urandom);
            push_task(rows[i], pres[i], pat);
            add_exp(rows[i], pres[i], pat);
        end
        prune_done = 1'b1;
        cycle();
        prune_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_finish(rows[i], ok);
            n_run++; if (!ok) begin n_fail++; $display("FAIL ad_finish[%0d]: got no FINISH expected FINISH row %0d", i, rows[i]); end
            n_run++; if (all_done !== 1'b0) begin n_fail++; $display("FAIL ad_early[%0d]: got %b expected 0", i, all_done); end
            complete(rows[i]);
        end
        n_run++; if (all_done !== 1'b1) begin n_fail++; $display("FAIL ad_level: got %b expected 1", all_done); end
        n_run++; if (obs.size() != exp_q.size()) begin n_fail++; $display("FAIL ad_count: got %0d expected %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_run++; if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL ad_op[%0d]: got %h expected %h", i, obs[i], exp_q[i]); end
        end
        tile_start = 1'b1;
        cycle();
        tile_start = 1'b0;
        n_run++; if (all_done !== 1'b0) begin n_fail++; $display("FAIL ad_clear: got %b expected 0", all_done); end
        clear_q();
        pat = 16'($urandom);
        push_task(8'd21, 8'd20, pat);
        repeat (8) cycle();
        n_run++; if (obs.size() != 0) begin n_fail++; $display("FAIL ad_rewait: got %0d ops expected 0", obs.size()); end
        complete(8'd20);
        add_exp(8'd21, 8'd20, pat);
        wait_ops(exp_q.size(), 60);
        n_run++; if (obs.size() != exp_q.size()) begin n_fail++; $display("FAIL ad_reissue_count: got %0d expected %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_run++; if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL ad_reissue_op[%0d]: got %h expected %h", i, obs[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_root_latency();
        test_dependency();
        test_random_stall();
        test_illegal_tile_start();
        test_fifo_full();
        test_all_done();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/prosparsity_dispatcher.md
Name: prosparsity_dispatcher

Overview:
Receiving end of the pruner→dispatcher task interface. Accepts pruned tasks {row_id, prefix_id, residual pattern} into a small FIFO. Enforces the prefix dependency: a row issues only after its prefix row has completed. Serializes each task into a stream of PE micro-ops (INIT, ACCUM per set pattern bit, FINISH) toward the accumulation PE.

Parameters:
N, 256, rows per tile; index width IW = clog2(N)
M, 16, pattern width (columns per tile); column index width CW = clog2(M)
FIFO_DEPTH, 8, task FIFO entries (power of 2, ≥4)
NULL_ID, 255, prefix_id value denoting "no prefix" (root)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
prefix_id  in  IW  task prefix row (NULL_ID or own row ⇒ root)
row_id_in  in  IW  task row index
pattern  in  M  residual spike pattern
prune_valid  in  1  task strobe, one cycle per task
prune_done  in  1  pulse: last task of tile has been sent
dispatch_ready  out  1  FIFO can absorb tasks
pe_valid  out  1  micro-op valid
pe_ready  in  1  PE accepts micro-op
pe_op  out  2  0=INIT_ZERO, 1=INIT_COPY, 2=ACCUM, 3=FINISH
pe_row_id  out  IW  target row
pe_prefix_id  out  IW  prefix row (INIT_COPY only; else 0)
pe_col_idx  out  CW  column to accumulate (ACCUM only; else 0)
pe_done_valid  in  1  PE reports row completion
pe_done_row  in  IW  completed row
tile_start  in  1  clear tile state
all_done  out  1  level: tile fully processed
err  out  1  sticky: overflow or illegal tile_start

Behaviour:
- Reset: all outputs 0 except dispatch_ready=1; FIFO empty; done bitmap cleared; FSM S_IDLE; counters 0; prune_done latch 0.
- Upstream is registered: prune_valid can arrive one cycle after dispatch_ready is observed high. dispatch_ready = (count ≤ FIFO_DEPTH-2), which reserves one skid slot.
- prune_valid with FIFO full: task dropped, err←1. Otherwise push at the clock edge; accepted_cnt++.
- Root task: prefix_id==NULL_ID or prefix_id==row_id_in. Consequence: row NULL_ID can never serve as another row's prefix (system contract).
- Ordering contract: the pruner emits rows in ascending NO order, so every prefix precedes its dependents. In-order head-of-line waiting is therefore deadlock-free.
- Head is eligible when FIFO is non-empty and (root or done_bitmap[prefix]).
- FSM:
  - S_IDLE: if head eligible, pop into working regs and go to S_INIT.
  - S_INIT: pe_valid=1, op INIT_ZERO (root) or INIT_COPY with pe_prefix_id. On pe_ready: go to S_ACC if pattern≠0, else S_FIN.
  - S_ACC: pe_op=ACCUM, pe_col_idx = lowest set bit of the working pattern. On pe_ready, clear that bit; when the cleared pattern becomes 0, go to S_FIN.
  - S_FIN: pe_op=FINISH. On pe_ready, go to S_IDLE.
- Handshake rules:
  - Micro-op transfers when pe_valid&&pe_ready.
  - While pe_valid=1 and pe_ready=0, payload is held stable.
  - pe_valid is never withdrawn before transfer.
- Latency: with empty FIFO, satisfied dependency and pe_ready=1, a task sampled at edge t gives INIT at edge t+2 and FINISH at edge t+3+popcount.
- Micro-ops per task = popcount(pattern)+2. Back-to-back tasks insert one S_IDLE cycle.
- pe_done_valid sets done_bitmap[pe_done_row] and increments done_cnt. A duplicate completion of the same row still increments done_cnt.
- Simultaneous push and pop in one cycle: count unchanged.
- prune_done is latched. all_done=1 when latch && FIFO empty && S_IDLE && done_cnt==accepted_cnt.
- tile_start:
  - Legal only in S_IDLE with an empty FIFO. It then clears the bitmap, counters, latch and all_done (err is kept).
  - Otherwise it is ignored and err←1.
- Reset mid-operation aborts the current task. Outstanding PE ops are the PE's responsibility.

Decomposition:
- Shared package (prosparsity_pkg): N, M, NULL_ID, IW/CW, pe_op encodings (OP_INIT_ZERO, OP_INIT_COPY, OP_ACCUM, OP_FINISH) and FSM state encodings.
- One sub-module: task_fifo, a synchronous FIFO of {row_id, prefix_id, pattern, is_root} with count output.
- Priority encoder (lowest set bit) stays inline.

Test Plan:
- Root task row=3, prefix=NULL_ID, pattern=16'h0005, pe_ready=1 → ops: INIT_ZERO(3), ACCUM col0, ACCUM col2, FINISH; INIT at t+2.
- Task row=7, prefix=3, pattern=16'h8000 issued before row 3 completes → pe_valid stays 0. pe_done_valid row 3 → INIT_COPY(7, prefix 3) next cycle, then ACCUM col15, FINISH.
- pe_ready toggling 1/0 during ACCUM → payload stable while stalled; exact popcount+2 transfers, no duplicates.
- Hold pe_ready=0 and push 7 tasks → dispatch_ready falls after count reaches 7. An 8th skid task is accepted; a 9th is dropped and err=1.
- 4 tasks, prune_done, 4 completions → all_done=1 one cycle after the last completion. tile_start → all_done=0, and a re-issued row waits on its prefix again.
- tile_start while the FSM is in S_ACC → ignored, err=1, current task completes normally.
